ct_ciu_snb_ac_cr_ctrl: RTL and testbench
========================================

Name: ct_ciu_snb_ac_cr_ctrl

Overview:
Per-SNB snoop channel controller. It is the AC producer and CR consumer facing the PIU snoop port.
- Accepts snoop requests from the SNB snoop queue (snpq) and drives snb_piu_acvalid/acbus to the PIU.
- Tracks outstanding snoops by 5-bit sid.
- Grants PIU CR responses and returns them to snpq.
- Instantiated once per SNB bank (snb0, snb1).

Parameters:
MAX_OUTSTD, 8, maximum snoops issued but not yet responded (1..32)
CNT_W, 6, width of the outstanding counter; must satisfy 2^CNT_W > MAX_OUTSTD
PA_W, 40, physical address width

Ports:
forever_cpuclk  in  1  clock
cpurst  in  1  reset
snpq_ac_req  in  1  snoop request valid
snpq_ac_sid  in  5  snoop id
snpq_ac_type  in  5  snoop type
snpq_ac_addr  in  40  snoop line address
snpq_ac_grant  out  1  request accepted this cycle
snb_piu_acvalid  out  1  AC valid to PIU
snb_piu_acbus  out  55  {5'b0, addr[39:0], sid[4:0], type[4:0]}
piu_snb_ac_grant  in  1  PIU accepts AC
piu_snb_cr_req  in  1  PIU CR valid
piu_snb_cr_bus  in  10  {sid[4:0], resp[4:0]}
snb_piu_cr_grant  out  1  CR accepted
snb_snpq_cr_vld  out  1  response to snpq valid
snb_snpq_cr_sid  out  5  response sid
snb_snpq_cr_resp  out  5  response code
snpq_snb_cr_rdy  in  1  snpq accepts response
snb_ac_outstd_cnt  out  CNT_W  outstanding snoop count
snb_cr_sid_err  out  1  sticky: CR received for non-pending sid
snb_ac_cr_idle  out  1  no staged AC, count 0, no response held

Behaviour:
Interface fact: one clock; reset is synchronous and active-high: the clock is forever_cpuclk and the reset is cpurst.

Reset values: every register is 0. Consequently:
- acvalid, snpq_ac_grant, cr_grant, cr_vld, outstd_cnt, sid_err all 0.
- idle is 1.
- pending[31:0] is 0.

AC stage (one-entry staging register):
- snpq_ac_grant = snpq_ac_req & slot_free & ~pending[sid] & ~(acvalid & staged_sid==sid) & (outstd_cnt + acvalid < MAX_OUTSTD).
- slot_free = ~acvalid | piu_snb_ac_grant.
- On snpq_ac_grant the entry is loaded; acvalid=1 from the next cycle.
- acbus is held stable while acvalid & ~ac_grant.
- On the AC handshake (acvalid & piu_snb_ac_grant), in the next cycle: pending[sid] is set and cnt is incremented. acvalid drops unless a new request is loaded in the same cycle. Back-to-back issue gives 1 AC per cycle.

CR stage:
- snb_piu_cr_grant = piu_snb_cr_req & (~snb_snpq_cr_vld | snpq_snb_cr_rdy). It is combinational, same cycle as the request.
- On grant with pending[sid]=1: pending[sid] is cleared, cnt is decremented, and the response register is loaded. cr_vld is 1 from the next cycle and is held until rdy.
- On grant with pending[sid]=0: the CR is consumed and dropped, not forwarded; snb_cr_sid_err is set and stays set until reset.

Simultaneous events:
- CR is evaluated against the pending state from before the cycle; the AC set is applied after. A CR for the sid being handshaken in the same cycle is therefore an error.
- AC handshake and valid CR in the same cycle leave cnt unchanged and both pending bits update.
- cr_vld & rdy & new grant in the same cycle: the register reloads and cr_vld stays 1.

Count limits: cnt never exceeds MAX_OUTSTD and never underflows. An underflow attempt is impossible because of the pending check.

Mid-operation reset: a synchronous cpurst in any cycle discards the staged AC, the pending vector and the held response. Outputs read reset values in the following cycle.

Idle: snb_ac_cr_idle = ~acvalid & cnt==0 & ~cr_vld.

Decomposition:
Shared package ct_ciu_snb_pkg holds:
- AC_WIDTH=55, CRR_WIDTH=10.
- AC field offsets: TYPE [4:0], SID [9:5], ADDR [49:10], RSVD [54:50].
- CR offsets: RESP [4:0], SID [9:5].
- SID_W=5.

Sub-module ct_ciu_snb_sid_track holds pending[31:0] and the counter. Its interface is set_vld/set_sid, clr_vld/clr_sid, and its outputs are hit(clr_sid), pending(query sid) and cnt.

Test Plan:
- Single snoop: sid=3, addr=0x12_3456_7840, type=2 -> acvalid next cycle with acbus=0x12345678_40_062 layout fields correct; grant -> cnt=1; CR {3,0x01} -> cr_grant same cycle, cr_vld next cycle sid=3 resp=1, cnt=0, idle=1.
- Fill: MAX_OUTSTD=8, PIU always granting, sids 0..9 requested -> exactly 8 ACs issued, snpq_ac_grant=0 for sids 8,9 until a CR for sid 0 arrives, then sid 8 issues the next cycle.
- Duplicate sid: sid 5 pending, request sid 5 -> snpq_ac_grant=0 until CR sid 5 is consumed.
- Backpressure: cr_vld held with rdy=0, CR req sid 1 -> cr_grant=0 for 3 cycles; rdy=1 -> grant in the same cycle and the register reloads to sid 1.
- Error: CR sid 7 with none pending -> cr_grant=1, cr_vld stays 0, sid_err=1 and sticky; AC handshake sid 7 with CR sid 7 in the same cycle -> sid_err=1, pending[7]=1.
- Reset mid-flight: cnt=3 with acvalid=1, assert cpurst for 1 cycle -> next cycle acvalid=0, cnt=0, sid_err=0, idle=1.

Source files
------------

// File: rtl/ct_ciu_snb_pkg.sv
// Shared definitions for the SNB snoop AC/CR channel controller.
// Holds bus widths, field offsets and the AC bus packing helper.
package ct_ciu_snb_pkg;

  localparam int SID_W     = 5;
  localparam int SID_NUM   = 1 << SID_W;
  localparam int TYPE_W    = 5;
  localparam int RESP_W    = 5;
  localparam int ADDR_W    = 40;

  localparam int AC_WIDTH  = 55;
  localparam int CRR_WIDTH = 10;

  localparam int AC_TYPE_LSB = 0;
  localparam int AC_SID_LSB  = 5;
  localparam int AC_ADDR_LSB = 10;
  localparam int AC_RSVD_LSB = 50;

  localparam int CR_RESP_LSB = 0;
  localparam int CR_SID_LSB  = 5;

  typedef struct packed {
    logic [AC_WIDTH-AC_RSVD_LSB-1:0] rsvd;
    logic [ADDR_W-1:0]               addr;
    logic [SID_W-1:0]                sid;
    logic [TYPE_W-1:0]               typ;
  } ac_bus_t;

  typedef struct packed {
    logic [SID_W-1:0]  sid;
    logic [RESP_W-1:0] resp;
  } cr_bus_t;

  function automatic logic [AC_WIDTH-1:0] pack_ac(
    input logic [ADDR_W-1:0] addr,
    input logic [SID_W-1:0]  sid,
    input logic [TYPE_W-1:0] typ
  );
    ac_bus_t b;
    b.rsvd = '0;
    b.addr = addr;
    b.sid  = sid;
    b.typ  = typ;
    return b;
  endfunction

endpackage

// File: rtl/ct_ciu_snb_sid_track.sv
// Outstanding snoop tracker: one pending bit per sid plus a count.
// Ports: clk/rst, set_vld/set_sid, clr_vld/clr_sid, q_sid;
//        hit (pending[clr_sid]), pend (pending[q_sid]), cnt.
module ct_ciu_snb_sid_track
  import ct_ciu_snb_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_vld,
  input  logic [SID_W-1:0] set_sid,
  input  logic             clr_vld,
  input  logic [SID_W-1:0] clr_sid,
  input  logic [SID_W-1:0] q_sid,
  output logic             hit,
  output logic             pend,
  output logic [CNT_W-1:0] cnt
);

  logic [SID_NUM-1:0] r_pending;
  logic [CNT_W-1:0]   r_cnt;
  logic [SID_NUM-1:0] w_pend_nxt;
  logic               w_clr;

  assign hit   = r_pending[clr_sid];
  assign pend  = r_pending[q_sid];
  assign cnt   = r_cnt;
  // A clear only counts when the sid was pending before this cycle.
  assign w_clr = clr_vld & hit;

  // Clear first, then set: a same-cycle set always wins.
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_clr)
      w_pend_nxt[clr_sid] = 1'b0;
    if (set_vld)
      w_pend_nxt[set_sid] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      unique case ({set_vld, w_clr})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ct_ciu_snb_ac_cr_ctrl.sv
// Per-SNB snoop channel controller: AC producer and CR consumer to PIU.
// Ports: snpq_ac_* in / grant out; snb_piu_ac* to PIU; piu_snb_cr_* in;
//        snb_snpq_cr_* to snpq; outstanding count, sticky sid error, idle.
module ct_ciu_snb_ac_cr_ctrl
  import ct_ciu_snb_pkg::*;
#(
  parameter int MAX_OUTSTD = 8,
  parameter int CNT_W      = 6,
  parameter int PA_W       = 40
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic                 snpq_ac_req,
  input  logic [SID_W-1:0]     snpq_ac_sid,
  input  logic [TYPE_W-1:0]    snpq_ac_type,
  input  logic [PA_W-1:0]      snpq_ac_addr,
  output logic                 snpq_ac_grant,
  output logic                 snb_piu_acvalid,
  output logic [AC_WIDTH-1:0]  snb_piu_acbus,
  input  logic                 piu_snb_ac_grant,
  input  logic                 piu_snb_cr_req,
  input  logic [CRR_WIDTH-1:0] piu_snb_cr_bus,
  output logic                 snb_piu_cr_grant,
  output logic                 snb_snpq_cr_vld,
  output logic [SID_W-1:0]     snb_snpq_cr_sid,
  output logic [RESP_W-1:0]    snb_snpq_cr_resp,
  input  logic                 snpq_snb_cr_rdy,
  output logic [CNT_W-1:0]     snb_ac_outstd_cnt,
  output logic                 snb_cr_sid_err,
  output logic                 snb_ac_cr_idle
);

  logic                r_acvalid;
  logic [SID_W-1:0]    r_ac_sid;
  logic [TYPE_W-1:0]   r_ac_type;
  logic [ADDR_W-1:0]   r_ac_addr;

  logic                r_cr_vld;
  logic [SID_W-1:0]    r_cr_sid;
  logic [RESP_W-1:0]   r_cr_resp;
  logic                r_sid_err;

  logic                w_slot_free;
  logic                w_ac_hs;
  logic                w_ac_take;
  logic                w_same_staged;
  logic                w_q_pend;
  logic                w_room;
  logic [CNT_W:0]      w_inflight;
  logic [CNT_W-1:0]    w_cnt;

  cr_bus_t             w_cr;
  logic                w_cr_grant;
  logic                w_cr_hit;
  logic                w_cr_fwd;

  assign w_cr = cr_bus_t'(piu_snb_cr_bus);

  ct_ciu_snb_sid_track #(
    .CNT_W (CNT_W)
  ) u_sid_track (
    .clk     (forever_cpuclk),
    .rst     (cpurst),
    .set_vld (w_ac_hs),
    .set_sid (r_ac_sid),
    .clr_vld (w_cr_grant),
    .clr_sid (w_cr.sid),
    .q_sid   (snpq_ac_sid),
    .hit     (w_cr_hit),
    .pend    (w_q_pend),
    .cnt     (w_cnt)
  );

  // AC side
  assign w_slot_free   = ~r_acvalid | piu_snb_ac_grant;
  assign w_ac_hs       = r_acvalid & piu_snb_ac_grant;
  assign w_same_staged = r_acvalid & (r_ac_sid == snpq_ac_sid);
  // The staged entry is counted so issue never overshoots the limit.
  assign w_inflight    = {1'b0, w_cnt} + {{CNT_W{1'b0}}, r_acvalid};
  assign w_room        = w_inflight < (CNT_W+1)'(MAX_OUTSTD);
  assign w_ac_take     = snpq_ac_req & w_slot_free & ~w_q_pend
                       & ~w_same_staged & w_room;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_acvalid <= 1'b0;
      r_ac_sid  <= '0;
      r_ac_type <= '0;
      r_ac_addr <= '0;
    end else if (w_ac_take) begin
      r_acvalid <= 1'b1;
      r_ac_sid  <= snpq_ac_sid;
      r_ac_type <= snpq_ac_type;
      r_ac_addr <= ADDR_W'(snpq_ac_addr);
    end else if (w_ac_hs) begin
      r_acvalid <= 1'b0;
    end
  end

  // CR side
  assign w_cr_grant = piu_snb_cr_req & (~r_cr_vld | snpq_snb_cr_rdy);
  assign w_cr_fwd   = w_cr_grant & w_cr_hit;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_cr_vld  <= 1'b0;
      r_cr_sid  <= '0;
      r_cr_resp <= '0;
      r_sid_err <= 1'b0;
    end else begin
      if (w_cr_fwd) begin
        r_cr_vld  <= 1'b1;
        r_cr_sid  <= w_cr.sid;
        r_cr_resp <= w_cr.resp;
      end else if (snpq_snb_cr_rdy) begin
        r_cr_vld  <= 1'b0;
      end
      // Stray CR: consumed, dropped, flagged until reset.
      if (w_cr_grant & ~w_cr_hit)
        r_sid_err <= 1'b1;
    end
  end

  assign snpq_ac_grant     = w_ac_take;
  assign snb_piu_acvalid   = r_acvalid;
  assign snb_piu_acbus     = pack_ac(r_ac_addr, r_ac_sid, r_ac_type);
  assign snb_piu_cr_grant  = w_cr_grant;
  assign snb_snpq_cr_vld   = r_cr_vld;
  assign snb_snpq_cr_sid   = r_cr_sid;
  assign snb_snpq_cr_resp  = r_cr_resp;
  assign snb_ac_outstd_cnt = w_cnt;
  assign snb_cr_sid_err    = r_sid_err;
  assign snb_ac_cr_idle    = ~r_acvalid & (w_cnt == '0) & ~r_cr_vld;

endmodule

// File: tb/tb_ct_ciu_snb_ac_cr_ctrl.sv
// Directed bench for the SNB snoop AC/CR channel controller.
// Inputs change 1ns after posedge; outputs are checked 1ns later.
module tb_ct_ciu_snb_ac_cr_ctrl;

  logic        clk;
  logic        cpurst;
  logic        snpq_ac_req;
  logic [4:0]  snpq_ac_sid;
  logic [4:0]  snpq_ac_type;
  logic [39:0] snpq_ac_addr;
  logic        snpq_ac_grant;
  logic        snb_piu_acvalid;
  logic [54:0] snb_piu_acbus;
  logic        piu_snb_ac_grant;
  logic        piu_snb_cr_req;
  logic [9:0]  piu_snb_cr_bus;
  logic        snb_piu_cr_grant;
  logic        snb_snpq_cr_vld;
  logic [4:0]  snb_snpq_cr_sid;
  logic [4:0]  snb_snpq_cr_resp;
  logic        snpq_snb_cr_rdy;
  logic [5:0]  snb_ac_outstd_cnt;
  logic        snb_cr_sid_err;
  logic        snb_ac_cr_idle;

  int n_run;
  int n_fail;
  int ac_hs;
  int hs_base;

  ct_ciu_snb_ac_cr_ctrl #(
    .MAX_OUTSTD (8),
    .CNT_W      (6),
    .PA_W       (40)
  ) dut (
    .forever_cpuclk    (clk),
    .cpurst            (cpurst),
    .snpq_ac_req       (snpq_ac_req),
    .snpq_ac_sid       (snpq_ac_sid),
    .snpq_ac_type      (snpq_ac_type),
    .snpq_ac_addr      (snpq_ac_addr),
    .snpq_ac_grant     (snpq_ac_grant),
    .snb_piu_acvalid   (snb_piu_acvalid),
    .snb_piu_acbus     (snb_piu_acbus),
    .piu_snb_ac_grant  (piu_snb_ac_grant),
    .piu_snb_cr_req    (piu_snb_cr_req),
    .piu_snb_cr_bus    (piu_snb_cr_bus),
    .snb_piu_cr_grant  (snb_piu_cr_grant),
    .snb_snpq_cr_vld   (snb_snpq_cr_vld),
    .snb_snpq_cr_sid   (snb_snpq_cr_sid),
    .snb_snpq_cr_resp  (snb_snpq_cr_resp),
    .snpq_snb_cr_rdy   (snpq_snb_cr_rdy),
    .snb_ac_outstd_cnt (snb_ac_outstd_cnt),
    .snb_cr_sid_err    (snb_cr_sid_err),
    .snb_ac_cr_idle    (snb_ac_cr_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial ac_hs = 0;
  always @(posedge clk)
    if (snb_piu_acvalid && piu_snb_ac_grant)
      ac_hs = ac_hs + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run = n_run + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset;
    cpurst = 1'b1;
    tick;
    tick;
    cpurst = 1'b0;
  endtask

  task automatic issue(input logic [4:0] sid);
    snpq_ac_req = 1'b1;
    snpq_ac_sid = sid;
    tick;
    snpq_ac_req = 1'b0;
    piu_snb_ac_grant = 1'b1;
    tick;
    piu_snb_ac_grant = 1'b0;
  endtask

  task automatic cr_drain(input logic [4:0] sid, input logic [4:0] resp);
    piu_snb_cr_req  = 1'b1;
    piu_snb_cr_bus  = {sid, resp};
    snpq_snb_cr_rdy = 1'b1;
    tick;
    piu_snb_cr_req  = 1'b0;
    tick;
    snpq_snb_cr_rdy = 1'b0;
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    cpurst = 1'b0;
    snpq_ac_req = 1'b0;
    snpq_ac_sid = '0;
    snpq_ac_type = '0;
    snpq_ac_addr = '0;
    piu_snb_ac_grant = 1'b0;
    piu_snb_cr_req = 1'b0;
    piu_snb_cr_bus = '0;
    snpq_snb_cr_rdy = 1'b0;

    // reset state
    do_reset;
    #1;
    chk("rst_acv", snb_piu_acvalid, 0);
    chk("rst_grant", snpq_ac_grant, 0);
    chk("rst_crg", snb_piu_cr_grant, 0);
    chk("rst_crv", snb_snpq_cr_vld, 0);
    chk("rst_cnt", snb_ac_outstd_cnt, 0);
    chk("rst_err", snb_cr_sid_err, 0);
    chk("rst_idle", snb_ac_cr_idle, 1);

    // single snoop
    snpq_ac_req = 1'b1;
    snpq_ac_sid = 5'd3;
    snpq_ac_type = 5'd2;
    snpq_ac_addr = 40'h12_3456_7840;
    #1 chk("t1_grant", snpq_ac_grant, 1);
    tick;
    snpq_ac_req = 1'b0;
    #1;
    chk("t1_acv", snb_piu_acvalid, 1);
    chk("t1_bus", snb_piu_acbus, 55'h48D1_59E1_0062);
    chk("t1_cnt0", snb_ac_outstd_cnt, 0);
    piu_snb_ac_grant = 1'b1;
    tick;
    piu_snb_ac_grant = 1'b0;
    #1;
    chk("t1_acv_off", snb_piu_acvalid, 0);
    chk("t1_cnt1", snb_ac_outstd_cnt, 1);
    chk("t1_busy", snb_ac_cr_idle, 0);
    piu_snb_cr_req = 1'b1;
    piu_snb_cr_bus = {5'd3, 5'd1};
    #1 chk("t1_crg", snb_piu_cr_grant, 1);
    tick;
    piu_snb_cr_req = 1'b0;
    #1;
    chk("t1_crv", snb_snpq_cr_vld, 1);
    chk("t1_crsid", snb_snpq_cr_sid, 3);
    chk("t1_crresp", snb_snpq_cr_resp, 1);
    chk("t1_cnt_back", snb_ac_outstd_cnt, 0);
    chk("t1_held_busy", snb_ac_cr_idle, 0);
    snpq_snb_cr_rdy = 1'b1;
    tick;
    snpq_snb_cr_rdy = 1'b0;
    #1;
    chk("t1_crv_off", snb_snpq_cr_vld, 0);
    chk("t1_idle", snb_ac_cr_idle, 1);

    // duplicate sid
    issue(5'd5);
    chk("dup_cnt", snb_ac_outstd_cnt, 1);
    snpq_ac_req = 1'b1;
    snpq_ac_sid = 5'd5;
    #1 chk("dup_blk0", snpq_ac_grant, 0);
    tick;
    chk("dup_blk1", snpq_ac_grant, 0);
    piu_snb_cr_req = 1'b1;
    piu_snb_cr_bus = {5'd5, 5'd0};
    snpq_snb_cr_rdy = 1'b1;
    #1;
    chk("dup_crg", snb_piu_cr_grant, 1);
    chk("dup_same_cyc", snpq_ac_grant, 0);
    tick;
    piu_snb_cr_req = 1'b0;
    #1 chk("dup_free", snpq_ac_grant, 1);
    tick;
    #1;
    chk("dup_staged_acv", snb_piu_acvalid, 1);
    chk("dup_staged_blk", snpq_ac_grant, 0);
    snpq_ac_req = 1'b0;
    piu_snb_ac_grant = 1'b1;
    tick;
    piu_snb_ac_grant = 1'b0;
    snpq_snb_cr_rdy = 1'b0;
    cr_drain(5'd5, 5'd0);
    chk("dup_end_cnt", snb_ac_outstd_cnt, 0);
    chk("dup_end_idle", snb_ac_cr_idle, 1);

    // back-to-back issue then CR backpressure
    snpq_ac_req = 1'b1;
    snpq_ac_sid = 5'd0;
    #1 chk("bb_g0", snpq_ac_grant, 1);
    tick;
    snpq_ac_sid = 5'd1;
    piu_snb_ac_grant = 1'b1;
    #1 chk("bb_g1", snpq_ac_grant, 1);
    tick;
    snpq_ac_req = 1'b0;
    #1;
    chk("bb_acv", snb_piu_acvalid, 1);
    chk("bb_cnt1", snb_ac_outstd_cnt, 1);
    tick;
    piu_snb_ac_grant = 1'b0;
    #1;
    chk("bb_cnt2", snb_ac_outstd_cnt, 2);
    chk("bb_acv_off", snb_piu_acvalid, 0);
    piu_snb_cr_req = 1'b1;
    piu_snb_cr_bus = {5'd0, 5'd4};
    #1 chk("bp_crg0", snb_piu_cr_grant, 1);
    tick;
    piu_snb_cr_bus = {5'd1, 5'd6};
    #1;
    chk("bp_crv", snb_snpq_cr_vld, 1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", snb_piu_cr_grant, 0);
      chk("bp_sid0", snb_snpq_cr_sid, 0);
      tick;
    end
    snpq_snb_cr_rdy = 1'b1;
    #1 chk("bp_release", snb_piu_cr_grant, 1);
    tick;
    piu_snb_cr_req = 1'b0;
    snpq_snb_cr_rdy = 1'b0;
    #1;
    chk("bp_reload_v", snb_snpq_cr_vld, 1);
    chk("bp_reload_sid", snb_snpq_cr_sid, 1);
    chk("bp_reload_resp", snb_snpq_cr_resp, 6);
    chk("bp_cnt", snb_ac_outstd_cnt, 0);
    snpq_snb_cr_rdy = 1'b1;
    tick;
    snpq_snb_cr_rdy = 1'b0;
    #1 chk("bp_idle", snb_ac_cr_idle, 1);

    // stray CR and same-cycle AC/CR on one sid
    piu_snb_cr_req = 1'b1;
    piu_snb_cr_bus = {5'd7, 5'd3};
    #1 chk("err_crg", snb_piu_cr_grant, 1);
    tick;
    piu_snb_cr_req = 1'b0;
    #1;
    chk("err_crv", snb_snpq_cr_vld, 0);
    chk("err_flag", snb_cr_sid_err, 1);
    chk("err_cnt", snb_ac_outstd_cnt, 0);
    tick;
    chk("err_sticky", snb_cr_sid_err, 1);
    snpq_ac_req = 1'b1;
    snpq_ac_sid = 5'd7;
    #1 chk("sim_g7", snpq_ac_grant, 1);
    tick;
    snpq_ac_req = 1'b0;
    piu_snb_ac_grant = 1'b1;
    piu_snb_cr_req = 1'b1;
    piu_snb_cr_bus = {5'd7, 5'd3};
    #1 chk("sim_crg", snb_piu_cr_grant, 1);
    tick;
    piu_snb_ac_grant = 1'b0;
    piu_snb_cr_req = 1'b0;
    #1;
    chk("sim_cnt", snb_ac_outstd_cnt, 1);
    chk("sim_crv", snb_snpq_cr_vld, 0);
    chk("sim_err", snb_cr_sid_err, 1);
    snpq_ac_req = 1'b1;
    #1 chk("sim_pend7", snpq_ac_grant, 0);
    snpq_ac_sid = 5'd2;
    tick;
    snpq_ac_req = 1'b0;
    piu_snb_ac_grant = 1'b1;
    piu_snb_cr_req = 1'b1;
    piu_snb_cr_bus = {5'd7, 5'd9};
    tick;
    piu_snb_ac_grant = 1'b0;
    piu_snb_cr_req = 1'b0;
    #1;
    chk("both_cnt", snb_ac_outstd_cnt, 1);
    chk("both_crv", snb_snpq_cr_vld, 1);
    chk("both_sid", snb_snpq_cr_sid, 7);
    chk("both_resp", snb_snpq_cr_resp, 9);
    snpq_snb_cr_rdy = 1'b1;
    tick;
    snpq_snb_cr_rdy = 1'b0;
    cr_drain(5'd2, 5'd0);
    chk("both_end_cnt", snb_ac_outstd_cnt, 0);

    // fill to the limit
    do_reset;
    #1 chk("fill_err_clr", snb_cr_sid_err, 0);
    hs_base = ac_hs;
    piu_snb_ac_grant = 1'b1;
    snpq_ac_req = 1'b1;
    for (int s = 0; s < 8; s++) begin
      snpq_ac_sid = 5'(s);
      #1 chk("fill_grant", snpq_ac_grant, 1);
      tick;
    end
    snpq_ac_sid = 5'd8;
    #1 chk("fill_blk8a", snpq_ac_grant, 0);
    tick;
    #1;
    chk("fill_cnt8", snb_ac_outstd_cnt, 8);
    chk("fill_acv_off", snb_piu_acvalid, 0);
    chk("fill_blk8b", snpq_ac_grant, 0);
    chk("fill_hs8", 64'(ac_hs - hs_base), 8);
    snpq_ac_sid = 5'd9;
    #1 chk("fill_blk9", snpq_ac_grant, 0);
    snpq_ac_sid = 5'd8;
    piu_snb_cr_req = 1'b1;
    piu_snb_cr_bus = {5'd0, 5'd0};
    snpq_snb_cr_rdy = 1'b1;
    #1;
    chk("fill_crg", snb_piu_cr_grant, 1);
    chk("fill_blk8c", snpq_ac_grant, 0);
    tick;
    piu_snb_cr_req = 1'b0;
    #1;
    chk("fill_cnt7", snb_ac_outstd_cnt, 7);
    chk("fill_g8", snpq_ac_grant, 1);
    tick;
    snpq_ac_req = 1'b0;
    #1;
    chk("fill_acv8", snb_piu_acvalid, 1);
    chk("fill_sid8", snb_piu_acbus[9:5], 8);
    tick;
    chk("fill_cnt8b", snb_ac_outstd_cnt, 8);
    piu_snb_ac_grant = 1'b0;
    snpq_snb_cr_rdy = 1'b0;

    // reset mid-flight
    do_reset;
    piu_snb_ac_grant = 1'b1;
    snpq_ac_req = 1'b1;
    for (int s = 0; s < 4; s++) begin
      snpq_ac_sid = 5'(s);
      tick;
    end
    snpq_ac_req = 1'b0;
    piu_snb_ac_grant = 1'b0;
    #1;
    chk("mid_cnt3", snb_ac_outstd_cnt, 3);
    chk("mid_acv", snb_piu_acvalid, 1);
    piu_snb_cr_req = 1'b1;
    piu_snb_cr_bus = {5'd20, 5'd0};
    tick;
    piu_snb_cr_req = 1'b0;
    #1 chk("mid_err", snb_cr_sid_err, 1);
    cpurst = 1'b1;
    tick;
    cpurst = 1'b0;
    #1;
    chk("mid_rst_acv", snb_piu_acvalid, 0);
    chk("mid_rst_cnt", snb_ac_outstd_cnt, 0);
    chk("mid_rst_err", snb_cr_sid_err, 0);
    chk("mid_rst_idle", snb_ac_cr_idle, 1);
    chk("mid_rst_crv", snb_snpq_cr_vld, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
